// File: rtl/alu_share_arb.sv
// alu_share_arb -- shares one ALU between the two issue lanes of the
// dual-issue core.
//
// Each lane offers an ALU operation on a valid/ready handshake. A
// round-robin arbiter grants one lane per cycle. The granted lane drives
// the shared alu, and the result lands in a one-entry output register that
// has its own valid/ready handshake toward writeback.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready      lane N handshake (N = 0, 1)
//   reqN_ctl/a/b/tag      lane N ALU control code, operands and tag
//   res_valid/ready       result register handshake
//   res_lane/tag/out      lane, tag and ALU result of the held result
//
// Optional feature (macro ALU_ARB_STALL_CNT_EN)
//   stall0_cnt, stall1_cnt  saturating 16-bit counters of cycles in which
//                           reqN_valid=1 and reqN_ready=0

// Combinational ALU.
// Control codes: 2 add, 6 sub, 0 and, 1 or, 12 nor, 13 xor, 7 slt (signed).
// Any other code gives 0.
module alu (
    input  logic [3:0]  ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out
);
    logic [31:0] sum;
    logic [31:0] diff;
    logic        ovf;
    logic        slt;

    always_comb begin
        sum  = a + b;
        diff = a + ~b + 32'd1;
        // Signed overflow of a-b: the operand signs differ and the sign of
        // the difference differs from the sign of a.
        ovf  = (a[31] != b[31]) && (diff[31] != a[31]);
        slt  = diff[31] ^ ovf;
        case (ctl)
            4'd2:    out = sum;
            4'd6:    out = diff;
            4'd0:    out = a & b;
            4'd1:    out = a | b;
            4'd12:   out = ~(a | b);
            4'd13:   out = a ^ b;
            4'd7:    out = {31'd0, slt};
            default: out = '0;
        endcase
    end
endmodule

module alu_share_arb #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [3:0]       req0_ctl,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_ctl,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_lane,
    output logic [TAG_W-1:0] res_tag,
    output logic [31:0]      res_out,
    input  logic             res_ready
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    output logic [15:0]      stall0_cnt,
    output logic [15:0]      stall1_cnt
`endif
);
    logic             res_valid_q, res_valid_d;
    logic             res_lane_q, res_lane_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [31:0]      res_out_q, res_out_d;
    logic             last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant;
    logic             accept;
    logic [3:0]       alu_ctl;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [31:0]      alu_out;

    // Grant and ready depend only on the handshake state, never on operands.
    always_comb begin
        can_accept = !res_valid_q || res_ready;
        // Both valid: take the lane that did not win last. Otherwise take
        // whichever lane is valid; with no request the mux idles on lane 0.
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        // Readies are held low while reset is asserted.
        req0_ready = !reset && can_accept && !grant && req0_valid;
        req1_ready = !reset && can_accept &&  grant && req1_valid;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        alu_ctl = grant ? req1_ctl : req0_ctl;
        alu_a   = grant ? req1_a   : req0_a;
        alu_b   = grant ? req1_b   : req0_b;
    end

    alu u_alu (
        .ctl (alu_ctl),
        .a   (alu_a),
        .b   (alu_b),
        .out (alu_out)
    );

    always_comb begin
        res_valid_d  = res_valid_q;
        res_lane_d   = res_lane_q;
        res_tag_d    = res_tag_q;
        res_out_d    = res_out_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            // Accepting while draining is allowed, so there is no bubble.
            res_valid_d  = 1'b1;
            res_lane_d   = grant;
            res_tag_d    = grant ? req1_tag : req0_tag;
            res_out_d    = alu_out;
            last_grant_d = grant;
        end else if (res_ready && res_valid_q) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_q  <= 1'b0;
            res_lane_q   <= 1'b0;
            res_tag_q    <= '0;
            res_out_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            res_valid_q  <= res_valid_d;
            res_lane_q   <= res_lane_d;
            res_tag_q    <= res_tag_d;
            res_out_q    <= res_out_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        res_valid = res_valid_q;
        res_lane  = res_lane_q;
        res_tag   = res_tag_q;
        res_out   = res_out_q;
    end

`ifdef ALU_ARB_STALL_CNT_EN
    logic [15:0] stall0_q, stall0_d;
    logic [15:0] stall1_q, stall1_d;

    always_comb begin
        stall0_d = stall0_q;
        stall1_d = stall1_q;
        if (req0_valid && !req0_ready && (stall0_q != '1)) begin
            stall0_d = stall0_q + 16'd1;
        end
        if (req1_valid && !req1_ready && (stall1_q != '1)) begin
            stall1_d = stall1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else begin
            stall0_q <= stall0_d;
            stall1_q <= stall1_d;
        end
    end

    always_comb begin
        stall0_cnt = stall0_q;
        stall1_cnt = stall1_q;
    end
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [3:0]       req0_ctl, req1_ctl;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             req0_ready, req1_ready;
    logic             res_valid, res_lane;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_out;
    logic             res_ready;
`ifdef ALU_ARB_STALL_CNT_EN
    logic [15:0]      stall0_cnt, stall1_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    alu_share_arb #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ctl   (req0_ctl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_ctl   (req1_ctl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_lane   (res_lane),
        .res_tag    (res_tag),
        .res_out    (res_out),
        .res_ready  (res_ready)
`ifdef ALU_ARB_STALL_CNT_EN
        ,
        .stall0_cnt (stall0_cnt),
        .stall1_cnt (stall1_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid;
    logic [31:0] m_out;
    bit          m_lane;
    logic [3:0]  m_tag;
    int          m_last;   // lane that won the most recent accepted transfer
    int          m_s0, m_s1;

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd12:   return ~(a | b);
            4'd13:   return a ^ b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Lane that must be accepted this cycle, or -1 for none.
    function automatic int exp_lane();
        if (reset) return -1;
        if (m_valid && !res_ready) return -1;
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_out = 0; m_lane = 0; m_tag = 0; m_last = 1;
            m_s0 = 0; m_s1 = 0;
        end else begin
            int l;
            l = exp_lane();
            if (req0_valid && l != 0 && m_s0 < 65535) m_s0++;
            if (req1_valid && l != 1 && m_s1 < 65535) m_s1++;
            if (l == 0) begin
                m_valid = 1; m_lane = 0; m_tag = req0_tag;
                m_out = ref_alu(req0_ctl, req0_a, req0_b); m_last = 0;
            end else if (l == 1) begin
                m_valid = 1; m_lane = 1; m_tag = req1_tag;
                m_out = ref_alu(req1_ctl, req1_a, req1_b); m_last = 1;
            end else if (res_ready && m_valid) begin
                m_valid = 0;
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        int l;
        l = exp_lane();
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, l == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, l == 1});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("res_out", res_out, m_out);
            chk("res_lane", {31'd0, res_lane}, {31'd0, m_lane});
            chk("res_tag", {28'd0, res_tag}, {28'd0, m_tag});
        end
`ifdef ALU_ARB_STALL_CNT_EN
        chk("stall0_cnt", {16'd0, stall0_cnt}, m_s0[31:0]);
        chk("stall1_cnt", {16'd0, stall1_cnt}, m_s1[31:0]);
`endif
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   g[4];
    int   n0, n1;

    initial begin
        vecs[0] = '{4'd1,  32'h0000_F00F, 32'h0F0F_0000, 32'h0F0F_F00F};
        vecs[1] = '{4'd12, 32'h0000_F00F, 32'h0F0F_0000, 32'hF0F0_0FF0};
        vecs[2] = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[3] = '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[4] = '{4'd7,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        vecs[5] = '{4'd5,  32'h0000_0003, 32'h0000_0004, 32'h0000_0000};
        vecs[6] = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{4'd6,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};

        reset = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 0; req0_b = 0; req0_tag = 0;
        req1_valid = 1'b0; req1_ctl = 4'd2; req1_a = 0; req1_b = 0; req1_tag = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", {31'd0, req0_ready}, 32'd0);
        chk("res_valid_in_reset", {31'd0, res_valid}, 32'd0);
        req0_valid = 1'b0;
        #1 reset = 1'b0;

        // Lane 0 add 5+7.
        req0_valid = 1; req0_ctl = 4'd2; req0_a = 5; req0_b = 7; req0_tag = 3; res_ready = 1;
        #1 chk("first_ready", {31'd0, req0_ready}, 32'd1);
        cycle();
        req0_valid = 0;
        chk("add_valid", {31'd0, res_valid}, 32'd1);
        chk("add_out", res_out, 32'd12);
        chk("add_lane", {31'd0, res_lane}, 32'd0);
        chk("add_tag", {28'd0, res_tag}, 32'd3);

        // Lane 1 signed slt.
        req1_valid = 1; req1_ctl = 4'd7; req1_a = 32'h8000_0000; req1_b = 1; req1_tag = 5;
        cycle();
        req1_valid = 0;
        chk("slt_out", res_out, 32'd1);
        chk("slt_lane", {31'd0, res_lane}, 32'd1);

        // Contention for 4 cycles: grants alternate starting with lane 0.
        req0_valid = 1; req0_ctl = 4'd0;  req0_a = 32'hF0F0_1234; req0_b = 32'h0FF0_FFFF; req0_tag = 1;
        req1_valid = 1; req1_ctl = 4'd13; req1_a = 32'hAAAA_5555; req1_b = 32'hFFFF_0000; req1_tag = 2;
        for (int i = 0; i < 4; i++) begin
            g[i] = 9;
            #2;
            if (req0_ready) g[i] = 0;
            if (req1_ready) g[i] = 1;
            cycle();
        end
        req0_valid = 0; req1_valid = 0;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("grant%0d", i), g[i], i % 2);
            if (g[i] == 0) n0++;
            if (g[i] == 1) n1++;
        end
        chk("lane0_accepts", n0, 2);
        chk("lane1_accepts", n1, 2);
        chk("xor_out", res_out, 32'h5555_5555);

        // Lane 0 sub with signed overflow.
        req0_valid = 1; req0_ctl = 4'd6; req0_a = 32'h7FFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_tag = 4;
        cycle();
        req0_valid = 0;
        chk("sub_out", res_out, 32'h8000_0000);

        // Output full and undrained for 3 cycles while both lanes wait.
        res_ready = 0;
        req0_valid = 1; req0_ctl = 4'd2;  req0_a = 1; req0_b = 1; req0_tag = 6;
        req1_valid = 1; req1_ctl = 4'd12; req1_a = 0; req1_b = 0; req1_tag = 7;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("hold_r0", {31'd0, req0_ready}, 32'd0);
            chk("hold_r1", {31'd0, req1_ready}, 32'd0);
            cycle();
            chk("hold_out", res_out, 32'h8000_0000);
        end
        // Drain and accept together; priority did not rotate while stalled.
        res_ready = 1;
        #1;
        chk("drain_r1", {31'd0, req1_ready}, 32'd1);
        chk("drain_r0", {31'd0, req0_ready}, 32'd0);
        cycle();
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        chk("drain_valid", {31'd0, res_valid}, 32'd1);
        chk("drain_lane", {31'd0, res_lane}, 32'd1);
        chk("drain_out", res_out, 32'hFFFF_FFFF);

        // Asynchronous reset with a pending result.
        #1 reset = 1;
        #1;
        chk("async_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("async_rst_out", res_out, 32'd0);
        cycle();
        reset = 0;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        #1;
        chk("post_rst_r0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_r1", {31'd0, req1_ready}, 32'd0);
        cycle();
        req0_valid = 0; req1_valid = 0;
        cycle();

        // Directed ALU vectors, alternating lanes.
        foreach (vecs[i]) begin
            if (i % 2 == 0) begin
                req0_valid = 1; req0_ctl = vecs[i].ctl; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_tag = 4'(i);
            end else begin
                req1_valid = 1; req1_ctl = vecs[i].ctl; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_tag = 4'(i);
            end
            cycle();
            req0_valid = 0; req1_valid = 0;
            chk($sformatf("vec%0d", i), res_out, vecs[i].exp);
        end
        cycle();

`ifdef ALU_ARB_STALL_CNT_EN
        // Lane 1 loses contention, then both wait on a full output.
        #1 reset = 1;
        cycle();
        reset = 0;
        res_ready = 0;
        req0_valid = 1; req1_valid = 1;
        repeat (5) cycle();
        chk("stall1_5", {16'd0, stall1_cnt}, 32'd5);
        chk("stall0_4", {16'd0, stall0_cnt}, 32'd4);
        repeat (70000) cycle();
        chk("stall1_sat", {16'd0, stall1_cnt}, 32'h0000_FFFF);
        chk("stall0_sat", {16'd0, stall0_cnt}, 32'h0000_FFFF);
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        repeat (2) cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
